// File: rtl/ps2_pkg.sv
// Shared constants, state type and parity helper for the PS/2 device transmitter.
package ps2_pkg;

  localparam int FRAME_BITS   = 11;
  localparam int GUARD_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_END  = 2'd3
  } state_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte queue feeding the PS/2 transmitter; head word is visible without a read strobe.
module ps2_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // The transmitter latches the head on the cycle it starts a frame, so read is combinational.
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues bytes and sends 11-bit frames on a device-clocked,
// open-collector bus, backing off on host inhibit and flagging host request-to-send.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int PS2_HZ      = 12_500,
  parameter int IDLE_CYCLES = 1250,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          CLK25,
  input  logic                          RST,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  output logic                          ps2_clk_oe,
  output logic                          ps2_data_oe,
  output logic                          busy,
  output logic                          abort_p,
  output logic                          host_rts_p,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int HALF = CLK_HZ / (2 * PS2_HZ);
  localparam int PW   = $clog2(HALF + 1);
  localparam int IW   = $clog2(IDLE_CYCLES + 1);

  logic          clk_meta_q, clk_s_q, data_meta_q, data_s_q, data_s_prev_q;
  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [10:0]   frame_q, frame_d;
  logic          abort_q, abort_d, rts_q, rts_d;
  logic          fifo_pop, fifo_full, fifo_empty, phase_last;
  logic [7:0]    fifo_head;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK25),
    .srst_i  (RST),
    .push_i  (tx_valid),
    .pop_i   (fifo_pop),
    .data_i  (tx_data),
    .data_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_ready    = !fifo_full;
  assign phase_last  = (phase_q == PW'(HALF - 1));
  assign ps2_clk_oe  = (state_q == ST_LOW);
  assign ps2_data_oe = ((state_q == ST_HIGH) || (state_q == ST_LOW)) && !frame_q[0];
  assign busy        = (state_q != ST_IDLE);
  assign abort_p     = abort_q;
  assign host_rts_p  = rts_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idle_cnt_d = idle_cnt_q;
    bit_idx_d  = bit_idx_q;
    frame_d    = frame_q;
    abort_d    = 1'b0;
    rts_d      = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        rts_d   = clk_s_q && data_s_prev_q && !data_s_q;
        // Idle time is only accumulated while a byte is waiting, so a push always sees a full idle window.
        if (!clk_s_q || !data_s_q || fifo_empty) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(IDLE_CYCLES)) begin
          state_d    = ST_HIGH;
          idle_cnt_d = '0;
          bit_idx_d  = '0;
          frame_d    = {1'b1, odd_parity(fifo_head), fifo_head, 1'b0};
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      ST_HIGH: begin
        if ((phase_q >= PW'(GUARD_CYCLES)) && !clk_s_q) begin
          state_d    = ST_IDLE;
          phase_d    = '0;
          idle_cnt_d = '0;
          abort_d    = 1'b1;
        end else if (phase_last) begin
          state_d = ST_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          phase_d   = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          frame_d   = {1'b1, frame_q[10:1]};
          state_d   = (bit_idx_q == 4'(FRAME_BITS - 1)) ? ST_END : ST_HIGH;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_END: begin
        if (phase_last) begin
          fifo_pop   = 1'b1;
          state_d    = ST_IDLE;
          phase_d    = '0;
          idle_cnt_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK25) begin
    if (RST) begin
      clk_meta_q    <= 1'b1;
      clk_s_q       <= 1'b1;
      data_meta_q   <= 1'b1;
      data_s_q      <= 1'b1;
      data_s_prev_q <= 1'b1;
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      idle_cnt_q    <= '0;
      bit_idx_q     <= '0;
      frame_q       <= '1;
      abort_q       <= 1'b0;
      rts_q         <= 1'b0;
    end else begin
      clk_meta_q    <= ps2_clk_i;
      clk_s_q       <= clk_meta_q;
      data_meta_q   <= ps2_data_i;
      data_s_q      <= data_meta_q;
      data_s_prev_q <= data_s_q;
      state_q       <= state_d;
      phase_q       <= phase_d;
      idle_cnt_q    <= idle_cnt_d;
      bit_idx_q     <= bit_idx_d;
      frame_q       <= frame_d;
      abort_q       <= abort_d;
      rts_q         <= rts_d;
    end
  end

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

PS/2 device-side transmitter. It emulates a PS/2 keyboard or mouse toward the core's PS/2 host port (ps2_clk_io / ps2_data_io), for loop-back test rigs and on-board key injection. It queues scancode bytes, generates the device-owned PS/2 clock, and serialises each byte as an 11-bit frame on open-collector lines. It honours host inhibit (clock held low) and request-to-send (data held low).

## Interface
- CLK_HZ, 25_000_000, system clock frequency
- PS2_HZ, 12_500, PS/2 bit clock; half-period H = CLK_HZ/(2*PS2_HZ) = 1000 cycles
- IDLE_CYCLES, 1250, bus-idle time (clock and data both high) required before a frame starts; 50 µs at 25 MHz
- FIFO_DEPTH, 8, byte queue depth; power of two
- CLK25  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- tx_data  in  8  byte to queue
- tx_valid  in  1  push request
- tx_ready  out  1  FIFO not full
- ps2_clk_i  in  1  raw PS/2 clock line level
- ps2_data_i  in  1  raw PS/2 data line level
- ps2_clk_oe  out  1  1 = drive clock low; 0 = release
- ps2_data_oe  out  1  1 = drive data low; 0 = release
- busy  out  1  frame in progress
- abort_p  out  1  one-cycle pulse when a frame is aborted by host inhibit
- host_rts_p  out  1  one-cycle pulse on data falling while clock high in IDLE
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued byte count

## Operation
- Inputs pass through a 2-flop synchroniser, giving clk_s and data_s.
- Frame: start 0, data bits 0..7 LSB first, odd parity, stop 1. A 1 is sent by releasing the line.
- States:
  - IDLE: lines released. Idle counter counts consecutive cycles with clk_s=1 and data_s=1, and clears otherwise. When the count reaches IDLE_CYCLES and the FIFO is not empty, load the head byte, set bit index 0 and go to HIGH.
  - HIGH (H cycles): clock released. ps2_data_oe is set from the current bit on the first cycle and held.
  - LOW (H cycles): clock driven low, data held. Then bit index increments. After bit 10 go to END, otherwise go to HIGH.
  - END (H cycles): all lines released. On exit, pop the FIFO, clear the idle counter and go to IDLE.
- Abort: if clk_s=0 in HIGH after a 4-cycle guard (synchroniser and line rise), then:
  - release both lines and pulse abort_p;
  - go to IDLE with the idle counter cleared;
  - do not pop; the same byte is resent later.
- host_rts_p: asserted in IDLE only, on clk_s=1 with a falling data_s. No frame may start while data_s=0. Host-to-device reception is out of scope.
- FIFO:
  - Push happens when tx_valid and tx_ready.
  - tx_ready = (fifo_level < FIFO_DEPTH), evaluated before any same-cycle pop, so a full FIFO rejects the push even on a pop cycle.
  - Simultaneous push and pop when not full leaves the level unchanged.
- Parity is the XOR-reduction of the byte, inverted.
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, abort_p=0, host_rts_p=0, fifo_level=0, tx_ready=1, state IDLE, idle counter 0.
- Reset mid-frame releases the lines on the next edge and discards the queue.

## Timing
- Push to first start-bit drive: at least IDLE_CYCLES+1 cycles on a quiet bus; push to fifo_level increment is 1 cycle.
- Complete frame: 22H cycles of driven bits plus H cycles in END, i.e. 23000 cycles at the defaults.
- Clock falling edges are 2H = 2000 cycles apart, 11 per frame. Data changes exactly H cycles before each falling edge.
- Gap between back-to-back frames: at least H + IDLE_CYCLES cycles.
- busy is 1 from the first HIGH cycle through the last END cycle.
- abort_p fires no later than 3 cycles after ps2_clk_i falls, once past the guard.

## Structure
- Package ps2_pkg holds:
  - frame length constant (11) and guard constant (4);
  - the state enum {IDLE, HIGH, LOW, END};
  - a parity function.
- Sub-module ps2_tx_fifo: synchronous FIFO with a FIFO_DEPTH parameter and ports push/pop/data/level/full/empty. The FSM, synchroniser and counters stay in the top module.

## Test plan
- Push 0x1C on an idle bus. Sampled at the 11 clock falls, data reads 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Falls are 2000 cycles apart, and busy spans 23000 cycles.
- Push 0xF0 then 0x1C in consecutive cycles. fifo_level reads 1 then 2. The 0xF0 frame carries parity 1, and the 0x1C frame starts at least 2250 cycles after the 0xF0 frame's last fall.
- Hold ps2_clk_i low for 20 cycles during bit 4 HIGH:
  - abort_p pulses once and the lines are released;
  - fifo_level is unchanged;
  - the byte is fully resent after 1250 idle cycles.
- Hold ps2_data_i low in IDLE. host_rts_p pulses once, no frame starts, and the frame starts 1250 cycles after release.
- Push 9 bytes with the bus held inhibited. tx_ready falls after the 8th push, the 9th push is ignored, and fifo_level is 8.
- Assert RST mid-frame at bit 6 LOW. Next cycle ps2_clk_oe=0, ps2_data_oe=0, busy=0 and fifo_level=0.
